multi_sink_fifo: RTL and testbench
==================================

Name: multi_sink_fifo

Overview:
- Consumer end of the VALID/CONSUMED multi-cycle channel driven by the base primitives (wire, pulse, reg).
- Accepts one token per handshake from a producer's OUT_READ/OUT_READ_VALID pair and returns CONSUMED.
- Buffers tokens in a DEPTH-entry FIFO and presents them to a plain ready/enable (normal-style) consumer.
- Sits at the boundary where a multi-cycle model is drained into single-cycle logic or a testbench monitor.

Parameters:
width, 1, token data width; 0 means a dataless channel: input VALID is treated as 1, DEQ_DATA is driven 0.
DEPTH, 4, FIFO entries; power of two, minimum 2.
AW, 2, pointer width; must equal log2(DEPTH).

Ports:
CLK  input  1  clock
RST_N  input  1  synchronous active-low reset
IN_READ  input  max(width,1)  token data from producer
IN_READ_VALID  input  1  producer token valid
IN_READ_CONSUMED  output  1  token accepted this cycle
FLUSH  input  1  synchronous clear of buffered tokens
DEQ_DATA  output  max(width,1)  head-of-FIFO data
DEQ_VALID  output  1  FIFO non-empty
DEQ_EN  input  1  consumer pops head this cycle
COUNT  output  AW+1  current occupancy, 0..DEPTH
TOKENS  output  16  accepted-token counter, wraps

Behaviour:
- Reset is decided: reset RST_N, synchronous, active-low; clock CLK.
- Reset (RST_N=0 at posedge): head, tail, COUNT and TOKENS go to 0; DEQ_VALID=0; storage is not reset; DEQ_DATA is don't-care while DEQ_VALID=0.
- v_in = (width==0) ? 1 : IN_READ_VALID.
- deq = DEQ_EN && DEQ_VALID. DEQ_EN is ignored when the FIFO is empty: no pointer or COUNT change.
- IN_READ_CONSUMED = v_in && !FLUSH && (COUNT<DEPTH || deq).
  - Combinational from DEQ_EN; the full-FIFO pass-through is intentional.
  - This output is 0 during reset cycles.
- enq = v_in && IN_READ_CONSUMED. Write storage[tail], tail+1 mod DEPTH, TOKENS+1 mod 2^16.
- On deq: head+1 mod DEPTH.
- COUNT update:
  - +1 on enq only.
  - -1 on deq only.
  - Unchanged on simultaneous enq and deq, including at full and at COUNT=1.
- Latency: a token accepted at edge N is visible on DEQ_DATA/DEQ_VALID after edge N. There is no empty-to-output bypass.
- DEQ_DATA = storage[head], registered read path, stable while not popped.
- Pointer wrap: tail and head wrap naturally at DEPTH. COUNT, not pointer equality, distinguishes full from empty.
- FLUSH=1 (RST_N=1):
  - At the edge: head=tail=0, COUNT=0.
  - No enqueue that cycle (CONSUMED=0); TOKENS unchanged; DEQ_EN ignored.
- Reset mid-stream: all buffered tokens are lost. The producer must re-present any token whose CONSUMED was not seen high.
- Each accepted token produces exactly one CONSUMED-high cycle. Back-to-back acceptance is allowed every cycle while space remains.
- Assertions (bench-side):
  - COUNT<=DEPTH.
  - No enq when COUNT==DEPTH && !deq.
  - DEQ_VALID == (COUNT!=0).

Test Plan:
- Reset then idle, DEPTH=4, width=8 -> COUNT=0, DEQ_VALID=0, IN_READ_CONSUMED=0, TOKENS=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, DEQ_EN=0 -> CONSUMED high 4 cycles; COUNT=4; 5th token 0x55 sees CONSUMED=0 and is held.
- From full, DEQ_EN=1 with 0x55 valid -> same cycle CONSUMED=1; DEQ_DATA 0x11 popped; COUNT stays 4; next head 0x22.
- Stream 10 tokens 0x00..0x09 with DEQ_EN=1 every cycle -> output order 0x00..0x09 one cycle after each acceptance; pointers wrap twice; TOKENS=10.
- With COUNT=3, assert FLUSH with VALID=1 -> CONSUMED=0 that cycle; COUNT=0 and DEQ_VALID=0 next cycle; TOKENS unchanged.
- width=0, DEPTH=2: VALID held 0, DEQ_EN=0 -> CONSUMED high 2 cycles then 0; 65537 accept/pop cycles -> TOKENS wraps to 1 (plus initial count).

Source files
------------

// File: rtl/multi_sink_fifo.sv
// Consumer end of a VALID/CONSUMED channel: buffers accepted tokens in a DEPTH-entry FIFO
// and presents the head to a ready/enable consumer. Synchronous active-low reset.
module multi_sink_fifo #(
    parameter int width = 1,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [((width > 0) ? width : 1)-1:0] IN_READ,
    input  logic                               IN_READ_VALID,
    output logic                               IN_READ_CONSUMED,
    input  logic                               FLUSH,
    output logic [((width > 0) ? width : 1)-1:0] DEQ_DATA,
    output logic                               DEQ_VALID,
    input  logic                               DEQ_EN,
    output logic [AW:0]                        COUNT,
    output logic [15:0]                        TOKENS
);

    localparam int          DW      = (width > 0) ? width : 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [15:0]   r_tokens;

    logic w_v_in;
    logic w_deq;
    logic w_enq;
    logic w_nonempty;

    assign w_nonempty = (r_count != '0);
    assign w_deq      = DEQ_EN && w_nonempty && !FLUSH;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_enq = RST_N && w_v_in && !FLUSH && ((r_count < C_DEPTH) || w_deq);

    assign IN_READ_CONSUMED = w_enq;
    assign DEQ_VALID        = w_nonempty;
    assign COUNT            = r_count;
    assign TOKENS           = r_tokens;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_tokens <= '0;
        end else if (FLUSH) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail   <= r_tail + AW'(1);
                r_tokens <= r_tokens + 16'd1;
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (width > 0) begin : g_data
            logic [DW-1:0] r_mem [DEPTH];

            always_ff @(posedge CLK) begin
                if (w_enq) begin
                    r_mem[r_tail] <= IN_READ;
                end
            end

            assign DEQ_DATA = r_mem[r_head];
            assign w_v_in   = IN_READ_VALID;
        end else begin : g_nodata
            // Dataless channel: every cycle offers a token, data pins are inert.
            logic w_unused_in;
            assign w_unused_in = ^{IN_READ, IN_READ_VALID};
            assign DEQ_DATA    = '0;
            assign w_v_in      = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_multi_sink_fifo.sv
// Bench for multi_sink_fifo: an 8-bit/4-deep and a dataless/2-deep instance checked each
// cycle against a queue-based reference model.
module tb_multi_sink_fifo;

    logic        CLK = 1'b0;
    logic        RST_N;

    logic [7:0]  in8;
    logic        v8, fl8, de8;
    logic        c8, dv8;
    logic [7:0]  dd8;
    logic [2:0]  cnt8;
    logic [15:0] tok8;

    logic        in0;
    logic        v0, fl0, de0;
    logic        c0, dv0;
    logic        dd0;
    logic [1:0]  cnt0;
    logic [15:0] tok0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_q[$];
    logic [15:0] m_tok8 = '0;
    int          m_cnt0 = 0;
    logic [15:0] m_tok0 = '0;

    always #5 CLK = ~CLK;

    multi_sink_fifo #(.width(8), .DEPTH(4), .AW(2)) u_dut8 (
        .CLK(CLK), .RST_N(RST_N),
        .IN_READ(in8), .IN_READ_VALID(v8), .IN_READ_CONSUMED(c8),
        .FLUSH(fl8), .DEQ_DATA(dd8), .DEQ_VALID(dv8), .DEQ_EN(de8),
        .COUNT(cnt8), .TOKENS(tok8)
    );

    multi_sink_fifo #(.width(0), .DEPTH(2), .AW(1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .IN_READ(in0), .IN_READ_VALID(v0), .IN_READ_CONSUMED(c0),
        .FLUSH(fl0), .DEQ_DATA(dd0), .DEQ_VALID(dv0), .DEQ_EN(de0),
        .COUNT(cnt0), .TOKENS(tok0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check just after, update the model at the rising edge.
    task automatic step(input logic rst_n,
                        input logic v8_i, input logic [7:0] d8_i, input logic fl8_i, input logic de8_i,
                        input logic v0_i, input logic fl0_i, input logic de0_i);
        logic deq8, deq0, exp_c8, exp_c0;
        RST_N = rst_n;
        v8 = v8_i; in8 = d8_i; fl8 = fl8_i; de8 = de8_i;
        v0 = v0_i; in0 = $urandom_range(1); fl0 = fl0_i; de0 = de0_i;
        #1;
        deq8   = de8_i && (m_q.size() != 0);
        exp_c8 = rst_n && v8_i && !fl8_i && ((m_q.size() < 4) || deq8);
        check("cons8",   32'(c8),   32'(exp_c8));
        check("count8",  32'(cnt8), 32'(m_q.size()));
        check("valid8",  32'(dv8),  32'(m_q.size() != 0));
        check("tokens8", 32'(tok8), 32'(m_tok8));
        if (m_q.size() != 0) check("data8", 32'(dd8), 32'(m_q[0]));
        check("count8_le_depth", 32'(cnt8 <= 3'd4), 32'd1);
        if (cnt8 == 3'd4 && !(de8_i && dv8)) check("no_enq_full8", 32'(c8), 32'd0);

        deq0   = de0_i && (m_cnt0 != 0);
        exp_c0 = rst_n && !fl0_i && ((m_cnt0 < 2) || deq0);
        check("cons0",   32'(c0),   32'(exp_c0));
        check("count0",  32'(cnt0), 32'(m_cnt0));
        check("valid0",  32'(dv0),  32'(m_cnt0 != 0));
        check("tokens0", 32'(tok0), 32'(m_tok0));
        check("data0",   32'(dd0),  32'd0);

        @(posedge CLK);
        if (!rst_n) begin
            m_q.delete();
            m_tok8 = '0;
            m_cnt0 = 0;
            m_tok0 = '0;
        end else begin
            if (fl8_i) m_q.delete();
            else begin
                if (deq8) void'(m_q.pop_front());
                if (exp_c8) begin
                    m_q.push_back(d8_i);
                    m_tok8 = m_tok8 + 16'd1;
                end
            end
            if (fl0_i) m_cnt0 = 0;
            else begin
                m_cnt0 = m_cnt0 - int'(deq0) + int'(exp_c0);
                if (exp_c0) m_tok0 = m_tok0 + 16'd1;
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        logic [15:0] tok0_base;
        RST_N = 1'b0;
        v8 = 1'b0; in8 = '0; fl8 = 1'b0; de8 = 1'b0;
        v0 = 1'b0; in0 = 1'b0; fl0 = 1'b0; de0 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        // Reset held with traffic offered: nothing may be consumed.
        step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_count8", 32'(cnt8), 32'd0);
        check("reset_tokens8", 32'(tok8), 32'd0);

        // Fill to full, then a fifth token must be held off.
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_count8", 32'(cnt8), 32'd4);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_held_count8", 32'(cnt8), 32'd4);

        // Full pass-through: pop 0x11 and accept 0x55 in the same cycle.
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pass_head8", 32'(dd8), 32'h22);
        check("pass_count8", 32'(cnt8), 32'd4);

        // Drop to three entries, then flush with a token offered.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_count8", 32'(cnt8), 32'd0);
        check("flush_tokens8", 32'(tok8), 32'd5);

        // Stream 0x00..0x09 while popping every cycle; pointers wrap twice.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stream_tokens8", 32'(tok8), 32'd15);

        // Reset mid-stream loses buffered tokens.
        step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset_count8", 32'(cnt8), 32'd0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++)
            step(1'b1, 1'($urandom_range(1)), 8'($urandom), ($urandom_range(15) == 0),
                 1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0),
                 1'($urandom_range(1)));

        // Dataless instance: VALID held 0 still fills two slots, then stalls.
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tok0_base = tok0;
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dataless_full_cons0", 32'(c0), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++)
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("dataless_wrap_tokens0", 32'(tok0), 32'(16'(tok0_base + 16'd3)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
